fpu_align: RTL
==============

Name: fpu_align

Overview:
- Operand-alignment stage that sits directly upstream of the fpu add/subtract datapath.
- Accepts a pair of IEEE-754 operands plus the operation code, and unpacks them, including the hidden bit.
- Orders the operands by exponent, then right-shifts the smaller mantissa serially, one bit per cycle, with guard/round/sticky retention.
- Presents a common exponent and two aligned extended mantissas to the adder over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width. Operand width W = 1+EXP_W+MAN_W (default 32). Extended mantissa width X = MAN_W+4: hidden bit, fraction, G, R, S.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept a pair.
- operation  in  2  00 add, 01 sub, 10/11 passed through untouched (treated as add for eff_sub).
- opa  in  W  operand A.
- opb  in  W  operand B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts result.
- out_exp  out  EXP_W  common (larger) effective exponent.
- out_man_large  out  X  mantissa of larger-exponent operand, unshifted.
- out_man_small  out  X  aligned mantissa of other operand; bit0 is sticky.
- out_sign_large  out  1  sign of larger operand (B sign already flipped for sub).
- out_eff_sub  out  1  effective subtraction: sign_large ^ sign_small.
- out_swapped  out  1  1 when B was the larger-exponent operand.
- out_operation  out  2  operation latched at acceptance.
- out_nan  out  1  either operand NaN.
- out_inf  out  1  either operand infinity (and neither NaN).

Behaviour:
- Reset (async, any state): FSM to IDLE; in_ready=1; out_valid=0; all data outputs 0.
- States: IDLE, CMP, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch opa, opb and operation, then go to CMP.
  - For sub, B's sign is inverted at latch.
- CMP (1 cycle):
  - Unpack each operand. Hidden = (exp != 0). Effective exp = 1 when exp == 0. Extended mantissa = {hidden, frac, 3'b000}.
  - If expB > expA, swap the operands and set swapped=1. Equal exponents: no swap.
  - Shift count = min(exp_large - exp_small, X).
  - If either exp is all-ones: set nan (frac != 0) or inf, and go to DONE with no shifting.
  - Else if count = 0, go to DONE; else go to SHIFT.
- SHIFT:
  - Each cycle: man_small <= {0, man_small[X-1:2], man_small[1] | man_small[0]}; count decrements.
  - When count reaches 0, go to DONE.
- DONE:
  - out_valid=1 and outputs stable.
  - Hold until out_ready=1; on that handshake cycle go to IDLE.
- in_ready is 0 in CMP, SHIFT and DONE; no overlap or pipelining of requests.
- Latency, acceptance edge to out_valid: 2 + count cycles. Diff 0 or special gives 2; maximum is 2+X (29 at default).
- Backpressure: in DONE with out_ready=0, outputs are held indefinitely and new inputs are ignored.
- Simultaneous in_valid while busy: ignored (in_ready=0).
- Reset mid-SHIFT: the partial result is discarded and out_valid does not assert.
- Zero and denormal operands are aligned normally (hidden=0, effective exp 1); no flagging.

Test Plan:
1. opa=0x3F800000, opb=0x3F800000, op=00, out_ready=1:
   - out_valid 2 cycles after acceptance.
   - out_exp=127, man_large=man_small=0x4000000, swapped=0, eff_sub=0.
2. opa=0x3F800000, opb=0x40800000 (4.0), op=01:
   - swapped=1, out_exp=129, man_large=0x4000000, man_small=0x1000000.
   - sign_large=1, eff_sub=1, latency 4.
3. Sticky: opa=0x3F800000, opb=0x33800001 (diff 24):
   - man_small=0x0000005 (bit2 from hidden, sticky set), latency 26.
4. Clamp: opa=0x7E800000, opb=0x00000001:
   - count clamped to 27, man_small=0x0000001, out_exp=253, latency 29.
5. Special: opa=0x7FC00000, opb=0x3F800000:
   - out_nan=1, out_inf=0, latency 2.
   - Same with opa=0x7F800000: out_inf=1.
6. Control:
   - Hold out_ready=0 for 5 cycles in DONE: outputs stable, in_ready=0; accept on the 6th cycle.
   - Assert rst during SHIFT of case 4: out_valid stays 0 and in_ready=1 immediately.

Source files
------------

// File: rtl/fpu_align.sv
// Operand-alignment stage ahead of the fpu add/subtract datapath: unpacks two IEEE-754
// operands, orders them by exponent and serially right-shifts the smaller mantissa with G/R/S.
module fpu_align #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           operation,
    input  logic [EXP_W+MAN_W:0] opa,
    input  logic [EXP_W+MAN_W:0] opb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W-1:0]     out_exp,
    output logic [MAN_W+3:0]     out_man_large,
    output logic [MAN_W+3:0]     out_man_small,
    output logic                 out_sign_large,
    output logic                 out_eff_sub,
    output logic                 out_swapped,
    output logic [1:0]           out_operation,
    output logic                 out_nan,
    output logic                 out_inf
);
    localparam int X     = MAN_W + 4;
    localparam int CNT_W = $clog2(X + 1);

    typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

    state_t state, state_next;

    logic [EXP_W+MAN_W:0] a_reg, b_reg;
    logic [CNT_W-1:0]     cnt;

    logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b, exp_l, exp_s, diff;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic [X-1:0]     man_a, man_b, man_l, man_s;
    logic             sign_a, sign_b, sign_l, sign_s;
    logic             swap, special, nan;
    logic [CNT_W-1:0] count;

    // One alignment step: bits falling off the bottom are folded into the sticky bit.
    function automatic logic [MAN_W+3:0] sticky_shr1(input logic [MAN_W+3:0] m);
        return {1'b0, m[MAN_W+3:2], m[1] | m[0]};
    endfunction

    always_comb begin
        sign_a = a_reg[EXP_W+MAN_W];
        sign_b = b_reg[EXP_W+MAN_W];
        exp_a  = a_reg[EXP_W+MAN_W-1:MAN_W];
        exp_b  = b_reg[EXP_W+MAN_W-1:MAN_W];
        frac_a = a_reg[MAN_W-1:0];
        frac_b = b_reg[MAN_W-1:0];
        // Denormals share the exponent of the smallest normal.
        eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
        man_a  = {(exp_a != '0), frac_a, 3'b000};
        man_b  = {(exp_b != '0), frac_b, 3'b000};
        swap   = eexp_b > eexp_a;
        if (swap) begin
            exp_l = eexp_b; exp_s = eexp_a;
            man_l = man_b;  man_s = man_a;
            sign_l = sign_b; sign_s = sign_a;
        end else begin
            exp_l = eexp_a; exp_s = eexp_b;
            man_l = man_a;  man_s = man_b;
            sign_l = sign_a; sign_s = sign_b;
        end
        diff    = exp_l - exp_s;
        count   = (32'(diff) > 32'(X)) ? CNT_W'(X) : CNT_W'(diff);
        special = (&exp_a) | (&exp_b);
        nan     = ((&exp_a) & (|frac_a)) | ((&exp_b) & (|frac_b));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CMP;
            end
            CMP: begin
                if (special || count == '0) state_next = DONE;
                else                        state_next = SHIFT;
            end
            SHIFT: begin
                if (cnt <= CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg          <= '0;
            b_reg          <= '0;
            cnt            <= '0;
            out_exp        <= '0;
            out_man_large  <= '0;
            out_man_small  <= '0;
            out_sign_large <= 1'b0;
            out_eff_sub    <= 1'b0;
            out_swapped    <= 1'b0;
            out_operation  <= '0;
            out_nan        <= 1'b0;
            out_inf        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg         <= opa;
                    b_reg         <= {opb[EXP_W+MAN_W] ^ (operation == 2'b01), opb[EXP_W+MAN_W-1:0]};
                    out_operation <= operation;
                end
                CMP: begin
                    out_exp        <= exp_l;
                    out_man_large  <= man_l;
                    out_man_small  <= man_s;
                    out_sign_large <= sign_l;
                    out_eff_sub    <= sign_l ^ sign_s;
                    out_swapped    <= swap;
                    out_nan        <= nan;
                    out_inf        <= special & ~nan;
                    cnt            <= special ? '0 : count;
                end
                SHIFT: begin
                    out_man_small <= sticky_shr1(out_man_small);
                    cnt           <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
